// File: rtl/me_mod_finalize.sv
// Final conditional subtraction for modular arithmetic: streams (A [+B]) mod M word by word.
// Computes both the raw sum and the sum minus M while loading, then picks one of them.
module me_mod_finalize #(
  parameter int K = 128,
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic         in_valid,
  input  logic [K-1:0] a_word,
  input  logic [K-1:0] b_word,
  input  logic [K-1:0] m_word,
  output logic         busy,
  output logic [K-1:0] res_word,
  output logic         res_valid,
  output logic         res_last,
  output logic         res_sub
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DECIDE = 2'd2,
    OUT    = 2'd3
  } state_t;

  state_t         state_r;
  logic [CW-1:0]  cnt_r;
  logic           c_r;
  logic           bw_r;
  logic           sel_r;
  logic           mode_r;
  logic           busy_r;
  logic [K-1:0]   res_word_r;
  logic           res_valid_r;
  logic           res_last_r;
  logic           res_sub_r;
  logic [K-1:0]   s_buf_r [N];
  logic [K-1:0]   d_buf_r [N];

  logic [K:0]     sum_s;
  logic [K:0]     diff_s;
  logic           wr_en_s;
  logic           last_cnt_s;

  // Word-serial add with carry and subtract-M with borrow, both in the same cycle.
  always_comb begin
    sum_s      = {1'b0, a_word} + {1'b0, (mode_r ? b_word : {K{1'b0}})} + {{K{1'b0}}, c_r};
    diff_s     = {1'b0, sum_s[K-1:0]} - {1'b0, m_word} - {{K{1'b0}}, bw_r};
    wr_en_s    = (state_r == LOAD) && in_valid;
    last_cnt_s = (cnt_r == CW'(N - 1));
  end

  // Operand buffers carry no reset; contents are only read after a full load.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      s_buf_r[cnt_r] <= sum_s[K-1:0];
      d_buf_r[cnt_r] <= diff_s[K-1:0];
    end
  end

  // Control FSM with registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      c_r         <= 1'b0;
      bw_r        <= 1'b0;
      sel_r       <= 1'b0;
      mode_r      <= 1'b0;
      busy_r      <= 1'b0;
      res_word_r  <= {K{1'b0}};
      res_valid_r <= 1'b0;
      res_last_r  <= 1'b0;
      res_sub_r   <= 1'b0;
    end else begin
      busy_r      <= 1'b1;
      res_word_r  <= {K{1'b0}};
      res_valid_r <= 1'b0;
      res_last_r  <= 1'b0;
      res_sub_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          busy_r <= start;
          if (start) begin
            state_r <= LOAD;
            mode_r  <= mode;
            c_r     <= 1'b0;
            bw_r    <= 1'b0;
            cnt_r   <= {CW{1'b0}};
          end
        end
        LOAD: begin
          if (in_valid) begin
            c_r  <= sum_s[K];
            bw_r <= diff_s[K];
            if (last_cnt_s) begin
              cnt_r   <= {CW{1'b0}};
              state_r <= DECIDE;
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
        end
        DECIDE: begin
          // Carry out or no borrow means the full sum is >= M.
          sel_r   <= c_r | ~bw_r;
          cnt_r   <= {CW{1'b0}};
          state_r <= OUT;
        end
        OUT: begin
          res_valid_r <= 1'b1;
          res_word_r  <= sel_r ? d_buf_r[cnt_r] : s_buf_r[cnt_r];
          res_sub_r   <= sel_r;
          res_last_r  <= last_cnt_s;
          if (last_cnt_s) begin
            cnt_r   <= {CW{1'b0}};
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign res_word  = res_word_r;
  assign res_valid = res_valid_r;
  assign res_last  = res_last_r;
  assign res_sub   = res_sub_r;

endmodule

// File: tb/tb_me_mod_finalize.sv
// Scoreboard bench for me_mod_finalize at K=8, N=4 with hand-computed directed vectors.
module tb_me_mod_finalize;

  localparam int K = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         mode;
  logic         in_valid;
  logic [K-1:0] a_word;
  logic [K-1:0] b_word;
  logic [K-1:0] m_word;
  logic         busy;
  logic [K-1:0] res_word;
  logic         res_valid;
  logic         res_last;
  logic         res_sub;

  typedef struct {
    logic [K-1:0] w;
    logic         sub;
    logic         last;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_low_cyc = -1;

  me_mod_finalize #(.K(K), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .in_valid(in_valid),
    .a_word(a_word), .b_word(b_word), .m_word(m_word), .busy(busy),
    .res_word(res_word), .res_valid(res_valid), .res_last(res_last), .res_sub(res_sub)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard whenever the DUT presents a word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_valid) begin
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL unexpected_word cyc=%0d got word=%h sub=%b last=%b, required no output",
                   cyc, res_word, res_sub, res_last);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (res_word !== e.w || res_sub !== e.sub || res_last !== e.last ||
              cyc != e.cyc || busy !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL result_word got w=%h sub=%b last=%b cyc=%0d busy=%b, required w=%h sub=%b last=%b cyc=%0d busy=1",
                     res_word, res_sub, res_last, cyc, busy, e.w, e.sub, e.last, e.cyc);
          end
          if (e.last) busy_low_cyc = e.cyc + 1;
        end
      end else begin
        checks = checks + 1;
        if (res_word !== {K{1'b0}} || res_last !== 1'b0 || res_sub !== 1'b0) begin
          errors = errors + 1;
          $display("FAIL idle_outputs cyc=%0d got word=%h last=%b sub=%b, required all 0",
                   cyc, res_word, res_last, res_sub);
        end
      end
      if (cyc == busy_low_cyc) begin
        checks = checks + 1;
        if (busy !== 1'b0) begin
          errors = errors + 1;
          $display("FAIL busy_drop cyc=%0d got busy=%b, required 0", cyc, busy);
        end
      end
    end
  end

  task automatic run_op(input logic md, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] m, input int gap, input logic [31:0] exp_r,
                        input logic exp_sub, input logic mid_start, input logic junk);
    int e;
    exp_t x;
    e = 0;
    @(negedge clk);
    start = 1'b1; mode = md; in_valid = junk;
    a_word = 8'hAA; b_word = 8'h55; m_word = 8'h33;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b0; mode = ~md;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      a_word = a[8*i +: 8]; b_word = b[8*i +: 8]; m_word = m[8*i +: 8];
      if (i == N - 1) e = cyc + 1;
    end
    for (int j = 0; j < N; j++) begin
      x.w = exp_r[8*j +: 8]; x.sub = exp_sub; x.last = (j == N - 1); x.cyc = e + 2 + j;
      exp_q.push_back(x);
    end
    @(negedge clk);
    in_valid = 1'b0;
    while (cyc < e + N + 3) begin
      @(negedge clk);
      start = (mid_start && cyc == e + 3) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; in_valid = 1'b0;
    a_word = 8'h00; b_word = 8'h00; m_word = 8'h00;
    repeat (3) @(negedge clk);
    checks = checks + 1;
    if (busy !== 1'b0 || res_valid !== 1'b0 || res_word !== 8'h00 || res_last !== 1'b0 || res_sub !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_state got busy=%b valid=%b word=%h last=%b sub=%b, required all 0",
               busy, res_valid, res_word, res_last, res_sub);
    end
    rst_n = 1'b1;
    // stray in_valid while idle must be ignored
    @(negedge clk); in_valid = 1'b1; a_word = 8'h77; m_word = 8'h11;
    @(negedge clk); in_valid = 1'b0;

    run_op(1'b0, 32'h80000016, 32'h0, 32'h80000011, 0, 32'h00000005, 1'b1, 1'b0, 1'b0);
    run_op(1'b0, 32'h12345678, 32'h0, 32'h80000011, 0, 32'h12345678, 1'b0, 1'b0, 1'b0);
    run_op(1'b1, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 0, 32'hFFFFFFFD, 1'b1, 1'b0, 1'b0);
    run_op(1'b1, 32'h00000100, 32'h00000001, 32'h00000101, 3, 32'h00000000, 1'b1, 1'b1, 1'b0);
    run_op(1'b0, 32'h80000011, 32'h0, 32'h80000011, 0, 32'h00000000, 1'b1, 1'b0, 1'b0);
    run_op(1'b0, 32'h80000010, 32'h0, 32'h80000011, 1, 32'h80000010, 1'b0, 1'b0, 1'b0);
    run_op(1'b1, 32'h000000F0, 32'h00000020, 32'h00000100, 0, 32'h00000010, 1'b1, 1'b0, 1'b1);
    run_op(1'b1, 32'h12340000, 32'h00005678, 32'h80000000, 2, 32'h12345678, 1'b0, 1'b0, 1'b0);

    // abort mid-load with reset, then a fresh operation
    @(negedge clk); start = 1'b1; mode = 1'b0; in_valid = 1'b0;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; a_word = 8'h16; m_word = 8'h11;
    @(negedge clk); a_word = 8'h00; m_word = 8'h00;
    @(negedge clk); in_valid = 1'b0;
    checks = checks + 1;
    if (busy !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL busy_in_load got %b, required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks = checks + 1;
    if (busy !== 1'b0 || res_valid !== 1'b0 || res_word !== 8'h00 || res_last !== 1'b0 || res_sub !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_abort got busy=%b valid=%b word=%h last=%b sub=%b, required all 0",
               busy, res_valid, res_word, res_last, res_sub);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    run_op(1'b0, 32'h12345678, 32'h0, 32'h80000011, 0, 32'h12345678, 1'b0, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL missing_words got %0d outstanding, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
